// File: rtl/data_memory_if.sv
// Bus bundle between the MEM stage and the data memory.
// The master drives address, data and enables; the slave returns read_data.
interface data_memory_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       addr;
  logic [DATA_W-1:0] write_data;
  logic              memread;
  logic              memwrite;
  logic [DATA_W-1:0] read_data;

  modport master (
    output addr,
    output write_data,
    output memread,
    output memwrite,
    input  read_data
  );

  modport slave (
    input  addr,
    input  write_data,
    input  memread,
    input  memwrite,
    output read_data
  );
endinterface

// File: rtl/data_memory.sv
// Word-indexed data memory: combinational gated read, synchronous write.
// Out-of-range addresses read as zero and never write; reset clears all words.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  data_memory_if.slave  bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              in_range;
  logic [ADDR_W-1:0] idx;

  assign in_range = (bus.addr[31:ADDR_W] == '0);
  assign idx      = bus.addr[ADDR_W-1:0];

  // Next contents: a known-high write enable updates one in-range word.
  always_comb begin
    mem_d = mem_q;
    if ((bus.memwrite == 1'b1) && in_range) begin
      mem_d[idx] = bus.write_data;
    end
  end

  // Storage update; reset wins over any concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read port: zero unless enabled, out of reset and in range.
  always_comb begin
    bus.read_data = '0;
    if (!rst && bus.memread && in_range) begin
      bus.read_data = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Randomized self-check of data_memory against an array reference model.
// Directed literal checks pin the model on the key corner cases.
module tb_data_memory;

  logic clk = 1'b0;
  logic rst;

  data_memory_if #(.DATA_W(32)) bus ();

  data_memory #(
    .DATA_W(32),
    .DEPTH (256),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [256];
  bit          started = 1'b0;

  // Reference model: reset clears everything; in-range writes land on the edge.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < 256; i++) model[i] = 32'h0;
      started = 1'b1;
    end else if (bus.memwrite === 1'b1 && bus.addr < 32'd256) begin
      model[bus.addr[7:0]] = bus.write_data;
    end
  end

  function automatic logic [31:0] expected_read();
    if (rst === 1'b1) return 32'h0;
    if (bus.memread === 1'b1 && bus.addr < 32'd256) return model[bus.addr[7:0]];
    return 32'h0;
  endfunction

  // Every-cycle comparison, mid-cycle, once contents are defined.
  always @(negedge clk) begin
    if (started) begin
      logic [31:0] exp_v;
      exp_v = expected_read();
      tests++;
      if (bus.read_data !== exp_v) begin
        fails++;
        $display("FAIL model_cmp addr=%h rst=%b rd=%b wr=%b got=%h exp=%h",
                 bus.addr, rst, bus.memread, bus.memwrite,
                 bus.read_data, exp_v);
      end
    end
  end

  task automatic drive(input logic r, input logic [31:0] a,
                       input logic [31:0] wd, input logic rd,
                       input logic wr);
    @(posedge clk);
    #1;
    rst            = r;
    bus.addr       = a;
    bus.write_data = wd;
    bus.memread    = rd;
    bus.memwrite   = wr;
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] exp_v);
    tests++;
    if (bus.read_data !== exp_v) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, bus.read_data, exp_v);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.addr       = 32'd0;
    bus.write_data = 32'h0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;

    // Reset: read forced low while asserted
    drive(1'b1, 32'd5, 32'h0, 1'b1, 1'b0);
    lit("rst_force0", 32'h0);
    drive(1'b1, 32'd255, 32'h0, 1'b1, 1'b0);
    lit("rst_force0_255", 32'h0);

    // Cleared contents
    drive(1'b0, 32'd1, 32'h0, 1'b1, 1'b0);   lit("clr_1", 32'h0);
    drive(1'b0, 32'd2, 32'h0, 1'b1, 1'b0);   lit("clr_2", 32'h0);
    drive(1'b0, 32'd4, 32'h0, 1'b1, 1'b0);   lit("clr_4", 32'h0);
    drive(1'b0, 32'd8, 32'h0, 1'b1, 1'b0);   lit("clr_8", 32'h0);
    drive(1'b0, 32'd255, 32'h0, 1'b1, 1'b0); lit("clr_255", 32'h0);

    // Write then read
    drive(1'b0, 32'd1, 32'hFFFFFFFE, 1'b0, 1'b1);
    drive(1'b0, 32'd1, 32'h0, 1'b1, 1'b0);
    lit("wr_rd_1", 32'hFFFFFFFE);
    drive(1'b0, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b1);
    drive(1'b0, 32'd2, 32'h0, 1'b1, 1'b0);
    lit("wr_rd_2", 32'hFFFFFFFD);

    // Write with read disabled
    drive(1'b0, 32'd4, 32'hFFFFFFFB, 1'b0, 1'b1);
    lit("wr_nord_4", 32'h0);
    drive(1'b0, 32'd4, 32'h0, 1'b1, 1'b0);
    lit("rd_4", 32'hFFFFFFFB);

    // Read during write: old before edge, new after
    drive(1'b0, 32'd8, 32'hFFFFFFF7, 1'b1, 1'b1);
    lit("rdw_before", 32'h0);
    drive(1'b0, 32'd8, 32'h0, 1'b1, 1'b0);
    lit("rdw_after", 32'hFFFFFFF7);
    drive(1'b0, 32'd9, 32'h0, 1'b1, 1'b0);
    lit("rdw_neighbor", 32'h0);

    // Out of range: no write, no alias onto word 0
    drive(1'b0, 32'd0, 32'hCAFEBABE, 1'b0, 1'b1);
    drive(1'b0, 32'h100, 32'h12345678, 1'b1, 1'b1);
    lit("oor_rd_during", 32'h0);
    drive(1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
    lit("oor_rd", 32'h0);
    drive(1'b0, 32'd0, 32'h0, 1'b1, 1'b0);
    lit("no_alias_0", 32'hCAFEBABE);

    // Reset beats concurrent write
    drive(1'b1, 32'd3, 32'hA5A5A5A5, 1'b1, 1'b1);
    lit("rst_pri_during", 32'h0);
    drive(1'b0, 32'd3, 32'h0, 1'b1, 1'b0);
    lit("rst_pri_3", 32'h0);
    drive(1'b0, 32'd1, 32'h0, 1'b1, 1'b0);
    lit("rst_cleared_1", 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic        r;
      int          sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'h100 + $urandom_range(0, 15);
      else if (sel < 10) a = $urandom_range(0, 15);
      else               a = $urandom_range(0, 255);
      r = ($urandom_range(0, 149) == 0);
      drive(r, a, $urandom, 1'($urandom), 1'($urandom));
    end

    drive(1'b0, 32'd0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
